// File: rtl/alarm_output_pio_if.sv
// Avalon-MM slave bus bundle for the alarm output PIO.
interface alarm_output_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/alarm_output_pio.sv
// Output PIO with set/clear aliases and per-bit blinking driven by a
// programmable half-period prescaler.
module alarm_output_pio #(
    parameter int unsigned WIDTH      = 8,
    parameter logic [15:0] PERIOD_RST = 16'd25000
) (
    input  logic                 clk,
    input  logic                 reset,
    alarm_output_pio_if.slave    bus,
    output logic [WIDTH-1:0]     out_port
);
    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrMask   = 3'd1;
    localparam logic [2:0] AddrPeriod = 3'd2;
    localparam logic [2:0] AddrStatus = 3'd3;
    localparam logic [2:0] AddrOutSet = 3'd4;
    localparam logic [2:0] AddrOutClr = 3'd5;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mask;
    logic [15:0]      r_period;
    logic [15:0]      r_cnt;
    logic             r_phase;
    logic [31:0]      r_readdata;
    logic [WIDTH-1:0] r_out;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_data_d;
    logic [WIDTH-1:0] w_mask_d;
    logic [15:0]      w_period_d;
    logic [15:0]      w_cnt_d;
    logic             w_phase_d;
    logic [WIDTH-1:0] w_out_d;
    logic [31:0]      w_rd_mux;

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[WIDTH-1:0];

    always_comb begin
        w_data_d   = r_data;
        w_mask_d   = r_mask;
        w_period_d = r_period;
        w_cnt_d    = r_cnt;
        w_phase_d  = r_phase;

        if (w_wr) begin
            case (bus.address)
                AddrData:   w_data_d   = w_wdata;
                AddrMask:   w_mask_d   = w_wdata;
                AddrPeriod: w_period_d = bus.writedata[15:0];
                AddrOutSet: w_data_d   = r_data | w_wdata;
                AddrOutClr: w_data_d   = r_data & ~w_wdata;
                default:    ;
            endcase
        end

        // A PERIOD write restarts the prescaler so a shorter period never overshoots.
        if (w_wr && bus.address == AddrPeriod) begin
            w_cnt_d   = 16'd0;
            w_phase_d = 1'b1;
        end else if (r_period == 16'd0) begin
            w_cnt_d   = 16'd0;
            w_phase_d = 1'b1;
        end else if (r_cnt == r_period - 16'd1) begin
            w_cnt_d   = 16'd0;
            w_phase_d = ~r_phase;
        end else begin
            w_cnt_d   = r_cnt + 16'd1;
        end

        w_out_d = w_data_d & ~(w_mask_d & {WIDTH{~w_phase_d}});
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (bus.address)
            AddrData:   w_rd_mux = 32'(r_data);
            AddrMask:   w_rd_mux = 32'(r_mask);
            AddrPeriod: w_rd_mux = {16'd0, r_period};
            AddrStatus: w_rd_mux = {31'd0, r_phase};
            default:    w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_mask     <= '0;
            r_period   <= PERIOD_RST;
            r_cnt      <= 16'd0;
            r_phase    <= 1'b1;
            r_out      <= '0;
            r_readdata <= 32'd0;
        end else begin
            r_data     <= w_data_d;
            r_mask     <= w_mask_d;
            r_period   <= w_period_d;
            r_cnt      <= w_cnt_d;
            r_phase    <= w_phase_d;
            r_out      <= w_out_d;
            r_readdata <= w_rd_mux;
        end
    end

    assign out_port     = r_out;
    assign bus.readdata = r_readdata;
endmodule

// File: tb/tb_alarm_output_pio.sv
// Directed bench for alarm_output_pio: register map, set/clear, blinking,
// period reprogramming and reset priority.
module tb_alarm_output_pio;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] out_port;
    int         n_vec = 0;
    int         n_err = 0;

    alarm_output_pio_if u_bus ();

    alarm_output_pio #(
        .WIDTH      (8),
        .PERIOD_RST (16'd25000)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (u_bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns 1ns after the write edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        u_bus.address    = a;
        u_bus.writedata  = d;
        u_bus.chipselect = 1'b1;
        u_bus.write_n    = 1'b0;
        tick();
        u_bus.chipselect = 1'b0;
        u_bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        u_bus.address = a;
        tick();
        d = u_bus.readdata;
    endtask

    logic [31:0] rv;
    logic [31:0] rst_exp [8];
    logic [7:0]  exp_out;

    initial begin
        u_bus.address    = 3'd0;
        u_bus.chipselect = 1'b0;
        u_bus.write_n    = 1'b1;
        u_bus.writedata  = 32'd0;
        reset            = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_out", 32'(out_port), 32'h0);
        check("reset_rd", u_bus.readdata, 32'h0);

        rst_exp = '{32'd0, 32'd0, 32'd25000, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), rv);
            check($sformatf("reset_addr%0d", a), rv, rst_exp[a]);
        end

        // Direct write, set and clear aliases.
        wr(3'd0, 32'hFFFF_FFA5);
        check("data_out", 32'(out_port), 32'hA5);
        rd(3'd0, rv);
        check("data_rd", rv, 32'hA5);
        wr(3'd4, 32'h0F);
        check("outset_out", 32'(out_port), 32'hAF);
        rd(3'd0, rv);
        check("outset_rd", rv, 32'hAF);
        wr(3'd5, 32'h81);
        check("outclr_out", 32'(out_port), 32'h2E);
        rd(3'd0, rv);
        check("outclr_rd", rv, 32'h2E);
        rd(3'd4, rv);
        check("outset_reads0", rv, 32'h0);
        wr(3'd3, 32'h0);
        rd(3'd3, rv);
        check("status_ro", rv, 32'h1);

        // PERIOD=4 blinking: four cycles on, four cycles off.
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'd4);
        u_bus.address = 3'd3;
        check("blink_out_k0", 32'(out_port), 32'hFF);
        for (int k = 1; k < 12; k++) begin
            tick();
            exp_out = (((k / 4) % 2) == 0) ? 8'hFF : 8'hF0;
            check($sformatf("blink_out_k%0d", k), 32'(out_port), 32'(exp_out));
            check($sformatf("blink_status_k%0d", k), u_bus.readdata,
                  ((((k - 1) / 4) % 2) == 0) ? 32'd1 : 32'd0);
        end
        rd(3'd2, rv);
        check("period_rd", rv, 32'd4);

        // PERIOD=0 holds the blink phase on.
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'h3C);
        wr(3'd2, 32'd0);
        u_bus.address = 3'd3;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("p0_out_k%0d", k), 32'(out_port), 32'h3C);
            check($sformatf("p0_status_k%0d", k), u_bus.readdata, 32'd1);
        end

        // Shrink PERIOD while the counter is well past the new terminal value.
        wr(3'd0, 32'hFF);
        wr(3'd2, 32'd100);
        repeat (90) tick();
        check("p100_still_on", 32'(out_port), 32'hFF);
        wr(3'd2, 32'd10);
        check("p10_k0", 32'(out_port), 32'hFF);
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_out = (k >= 10 && k < 20) ? 8'h00 : 8'hFF;
            if (k == 9 || k == 10 || k == 19 || k == 20)
                check($sformatf("p10_k%0d", k), 32'(out_port), 32'(exp_out));
        end

        // Reset during blinking wins over a simultaneous DATA write.
        repeat (3) tick();
        reset            = 1'b1;
        u_bus.address    = 3'd0;
        u_bus.writedata  = 32'h55;
        u_bus.chipselect = 1'b1;
        u_bus.write_n    = 1'b0;
        tick();
        reset            = 1'b0;
        u_bus.chipselect = 1'b0;
        u_bus.write_n    = 1'b1;
        check("rstwr_out", 32'(out_port), 32'h0);
        check("rstwr_rd", u_bus.readdata, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(3'(a), rv);
            check($sformatf("rstwr_addr%0d", a), rv, rst_exp[a]);
        end
        check("rstwr_out_after", 32'(out_port), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alarm_output_pio.md
ALARM_OUTPUT_PIO -- requirements
Module: alarm_output_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the number of output port bits (1..32).
REQ-002 The block SHALL have parameter PERIOD_RST, default 16'd25000, the reset value of the blink half-period register.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port address  input  3  Avalon-MM slave word address.
REQ-006 Port chipselect  input  1  slave select.
REQ-007 Port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-008 Port writedata  input  32  write data; only bits [WIDTH-1:0] (or [15:0] for PERIOD) used.
REQ-009 Port readdata  output  32  registered read data, unused upper bits zero.
REQ-010 Port out_port  output  WIDTH  driven output pins (LEDs, buzzer), registered.

Function
REQ-011 The block SHALL implement the register map: 0 DATA (R/W), 1 BLINK_MASK (R/W), 2 PERIOD (R/W, 16 bits), 3 STATUS (RO: bit0 = blink phase), 4 OUTSET (WO), 5 OUTCLEAR (WO), 6-7 reserved.
REQ-012 A write SHALL occur when chipselect=1 and write_n=0 and take effect at the next rising edge.
REQ-013 Write to DATA SHALL load DATA <= writedata[WIDTH-1:0].
REQ-014 Write to OUTSET SHALL perform DATA <= DATA | writedata[WIDTH-1:0]; write to OUTCLEAR SHALL perform DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-015 Write to BLINK_MASK SHALL load BLINK_MASK <= writedata[WIDTH-1:0].
REQ-016 Write to PERIOD SHALL load PERIOD <= writedata[15:0], clear the prescaler counter to 0 and set blink phase to 1 in the same edge.
REQ-017 Writes to STATUS and addresses 6-7 SHALL have no effect.
REQ-018 readdata SHALL be updated every clock (no chipselect qualification) with the mux of address: DATA, BLINK_MASK, {16'b0,PERIOD}, {31'b0,phase}; OUTSET, OUTCLEAR, 6, 7 read 0; read latency is one cycle.
REQ-019 Prescaler: 16-bit counter; when PERIOD != 0, counter increments each cycle; when counter == PERIOD-1 it SHALL wrap to 0 and phase SHALL toggle in the same edge.
REQ-020 When PERIOD == 0, counter SHALL hold at 0 and phase SHALL be forced to 1 (blinking bits steady on).
REQ-021 If PERIOD is written to a value <= current counter, the counter clear of REQ-016 SHALL prevent counting past the terminal value.
REQ-022 out_port SHALL be registered: out_port <= DATA_next & ~(BLINK_MASK_next & {WIDTH{~phase_next}}), i.e. reflects a register write one cycle after the write edge with no extra stage beyond REQ-012 (total one-cycle write-to-pin latency).
REQ-023 Bits with BLINK_MASK=0 SHALL follow DATA steadily; bits with BLINK_MASK=1 and DATA=1 SHALL be high only while phase=1; bits with DATA=0 SHALL be low regardless of mask.
REQ-024 Blink full period SHALL be 2*PERIOD clock cycles with 50% duty.

Reset
REQ-025 While reset=1 at a rising edge: DATA=0, BLINK_MASK=0, PERIOD=PERIOD_RST, counter=0, phase=1, out_port=0, readdata=0.
REQ-026 Reset SHALL take priority over any simultaneous write; a write presented in a reset cycle SHALL be lost.
REQ-027 Reset asserted mid-blink SHALL restart the prescaler from 0 with phase=1 on release.

Verification
REQ-028 Reset, then read all addresses -> readdata 0,0,PERIOD_RST,1,0,0,0,0 each one cycle after address applied; out_port=0.
REQ-029 Write DATA=0xA5, OUTSET=0x0F, OUTCLEAR=0x81 -> DATA reads 0xA5, 0xAF, 0x2E; out_port matches one cycle after each write edge.
REQ-030 PERIOD=4, DATA=0xFF, BLINK_MASK=0x0F -> out_port alternates 0xFF for 4 cycles / 0xF0 for 4 cycles; STATUS bit0 tracks phase.
REQ-031 PERIOD=0 with BLINK_MASK=0xFF, DATA=0x3C -> out_port steady 0x3C, counter static, STATUS=1.
REQ-032 PERIOD=100 running, counter near 90, write PERIOD=10 -> counter restarts at 0, first toggle after exactly 10 cycles.
REQ-033 Assert reset for one cycle concurrent with write DATA=0x55 during blinking -> all registers at reset values, DATA=0, out_port=0.
